fetch_unit: RTL and testbench

//  Instruction-fetch stage: owns the PC, issues in-order word fetches to instruction memory and buffers

---
 rtl/riscv_pkg.sv | 16 +
 rtl/fetch_unit_if.sv | 33 +++
 rtl/fetch_unit_sync_fifo.sv | 77 +++++++
 rtl/fetch_unit.sv | 123 ++++++++++++
 tb/tb_fetch_unit.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// riscv_pkg: shared widths, NOP encoding and the fetch-queue entry.
// Rev 1.0
// ------------------------------------------------------------------
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ------------------------------------------------------------------
// fetch_unit_if: imem request/response, redirect and decode handshake.
// Rev 1.0
// ------------------------------------------------------------------
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic                            imem_req_valid;
  logic [XLEN-1:0]                 imem_req_addr;
  logic                            imem_req_ready;
  logic                            imem_rsp_valid;
  logic [riscv_pkg::INSTR_W-1:0]   imem_rsp_instr;
  logic                            redirect_valid;
  logic [XLEN-1:0]                 redirect_pc;
  logic                            id_valid;
  logic [riscv_pkg::INSTR_W-1:0]   id_instr;
  logic [XLEN-1:0]                 id_pc;
  logic                            id_ready;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_instr,
           redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_instr,
           redirect_valid, redirect_pc, id_ready
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit_sync_fifo.sv
`default_nettype none
// ------------------------------------------------------------------
// sync_fifo: single-clock FIFO with flush, occupancy count and pop-while-full.
// Rev 1.0
// ------------------------------------------------------------------
module sync_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  T              push_data,
  input  logic          pop,
  output T              pop_data,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);
  T              mem_q [DEPTH];
  T              mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ------------------------------------------------------------------
// fetch_unit: PC owner, in-order imem fetch, {pc,instr} queue toward decode.
// Rev 1.0
// ------------------------------------------------------------------
module fetch_unit #(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              FQ_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);
  import riscv_pkg::*;

  localparam int             CW      = $clog2(FQ_DEPTH) + 1;
  localparam logic [CW:0]    DEPTH_C = (CW + 1)'(FQ_DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

  logic [CW-1:0]   if_count;
  logic            if_empty;
  logic            if_full;
  logic [XLEN-1:0] if_pc;
  logic [CW-1:0]   fq_count;
  logic            fq_empty;
  logic            fq_full;
  fetch_entry_t    fq_head;
  fetch_entry_t    fq_push_data;

  logic [CW:0]     outstanding;
  logic            credit_ok;
  logic            req_fire;
  logic            rsp_fire;
  logic            fq_push;
  logic            fq_pop;

  // Credit counts every outstanding fetch, stale ones included, so the
  // in-flight PC FIFO can never overflow across repeated redirects.
  assign outstanding = {1'b0, if_count} + {1'b0, fq_count};
  assign credit_ok   = (outstanding < DEPTH_C);

  assign bus.imem_req_valid = ~rst & ~bus.redirect_valid & credit_ok;
  assign bus.imem_req_addr  = pc_q;
  assign req_fire           = bus.imem_req_valid & bus.imem_req_ready;

  assign rsp_fire     = bus.imem_rsp_valid & ~if_empty;
  assign fq_push      = rsp_fire & ~bus.redirect_valid & (drop_cnt_q == '0);
  assign fq_push_data = '{pc: if_pc, instr: bus.imem_rsp_instr};

  assign bus.id_valid = ~fq_empty & ~bus.redirect_valid;
  assign bus.id_instr = fq_empty ? NOP_INSTR : fq_head.instr;
  assign bus.id_pc    = fq_empty ? pc_q : fq_head.pc;
  assign fq_pop       = bus.id_valid & bus.id_ready;

  always_comb begin
    pc_d       = pc_q;
    drop_cnt_d = drop_cnt_q;
    if (bus.redirect_valid) begin
      pc_d       = bus.redirect_pc & ~XLEN'(3);
      drop_cnt_d = if_count - CW'(rsp_fire);
    end else begin
      if (req_fire) begin
        pc_d = pc_q + XLEN'(4);
      end
      if (rsp_fire && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  sync_fifo #(
    .T     (logic [XLEN-1:0]),
    .DEPTH (FQ_DEPTH)
  ) u_inflight_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (req_fire),
    .push_data (pc_q),
    .pop       (rsp_fire),
    .pop_data  (if_pc),
    .count     (if_count),
    .empty     (if_empty),
    .full      (if_full)
  );

  sync_fifo #(
    .T     (fetch_entry_t),
    .DEPTH (FQ_DEPTH)
  ) u_fetch_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.redirect_valid),
    .push      (fq_push),
    .push_data (fq_push_data),
    .pop       (fq_pop),
    .pop_data  (fq_head),
    .count     (fq_count),
    .empty     (fq_empty),
    .full      (fq_full)
  );

  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
    bus.imem_rsp_valid |-> !if_empty);
  a_inflight_no_overflow: assert property (@(posedge clk) disable iff (rst)
    req_fire |-> !if_full);
  a_queue_no_overflow: assert property (@(posedge clk) disable iff (rst)
    fq_push |-> (!fq_full || fq_pop));
endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_fetch_unit: directed scenarios plus random traffic against a queue model.
// Rev 1.0
// ------------------------------------------------------------------
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam logic [31:0] RST_PC = 32'h100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(32)) bus ();

  fetch_unit #(
    .XLEN     (32),
    .RESET_PC (RST_PC),
    .FQ_DEPTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct { logic [31:0] pc; bit stale; } out_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct { logic [31:0] addr; int cyc; } mreq_t;

  logic [31:0] m_pc;
  out_t        m_out[$];
  ent_t        m_fq[$];
  mreq_t       mem_q[$];
  int          cyc_n;
  int          n_checks;
  int          n_pass;

  bit          o_req_valid, o_req_fire, o_id_valid;
  logic [31:0] o_addr, o_id_pc, o_id_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock: drive inputs at negedge, compare against the model, advance model.
  task automatic cycle(input bit rst_i, input bit redir, input logic [31:0] rpc,
                       input bit mrdy, input bit rsp_en, input bit idr);
    bit   e_req_valid, e_id_valid, rsp;
    out_t o;
    @(negedge clk);
    rst                = rst_i;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.imem_req_ready = mrdy;
    bus.id_ready       = idr;
    rsp = !rst_i && rsp_en && (mem_q.size() > 0) && (mem_q[0].cyc < cyc_n);
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_instr = rsp ? mem_word(mem_q[0].addr) : $urandom;
    #1;
    o_req_valid = bus.imem_req_valid;
    o_addr      = bus.imem_req_addr;
    o_req_fire  = o_req_valid & mrdy;
    o_id_valid  = bus.id_valid;
    o_id_pc     = bus.id_pc;
    o_id_instr  = bus.id_instr;

    e_req_valid = !rst_i && !redir && ((m_out.size() + m_fq.size()) < 4);
    e_id_valid  = !redir && (m_fq.size() > 0);
    if (cyc_n > 0) begin
      check("req_valid", o_req_valid, e_req_valid);
      if (e_req_valid) check("req_addr", o_addr, m_pc);
      check("id_valid", o_id_valid, e_id_valid);
      if (m_fq.size() > 0) begin
        check("id_pc", o_id_pc, m_fq[0].pc);
        check("id_instr", o_id_instr, m_fq[0].instr);
      end else begin
        check("id_instr_nop", o_id_instr, NOP_INSTR);
      end
    end

    if (rsp) void'(mem_q.pop_front());
    if (o_req_fire) mem_q.push_back('{addr: o_addr, cyc: cyc_n});

    if (rst_i) begin
      m_pc = RST_PC;
      m_out.delete();
      m_fq.delete();
      mem_q.delete();
    end else if (redir) begin
      m_pc = rpc & ~32'h3;
      foreach (m_out[i]) m_out[i].stale = 1'b1;
      if (rsp && m_out.size() > 0) void'(m_out.pop_front());
      m_fq.delete();
    end else begin
      if (e_id_valid && idr) void'(m_fq.pop_front());
      if (rsp && m_out.size() > 0) begin
        o = m_out.pop_front();
        if (!o.stale) m_fq.push_back('{pc: o.pc, instr: mem_word(o.pc)});
      end
      if (e_req_valid && mrdy) begin
        m_out.push_back('{pc: m_pc, stale: 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
    cyc_n++;
  endtask

  task automatic wait_first_id(input int budget, output bit seen, output logic [31:0] pc);
    seen = 1'b0;
    pc   = '0;
    for (int k = 0; k < budget && !seen; k++) begin
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
      if (o_id_valid) begin
        seen = 1'b1;
        pc   = o_id_pc;
      end
    end
  endtask

  initial begin
    bit          seen, r, rd;
    logic [31:0] fpc, rp;
    int          fires;
    n_checks = 0;
    n_pass   = 0;
    cyc_n    = 0;
    m_pc     = RST_PC;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_instr = '0;
    bus.id_ready       = 1'b0;

    // Reset values and first request
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    check("t1_id_pc_rst", o_id_pc, RST_PC);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    check("t1_req_valid", o_req_valid, 1);
    check("t1_addr", o_addr, 32'h100);
    check("t1_id_valid", o_id_valid, 0);
    check("t1_id_instr", o_id_instr, NOP_INSTR);

    // Streaming: first id at N+2 then one per cycle
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    check("t2_id_valid_n1", o_id_valid, 0);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    check("t2_id_valid_n2", o_id_valid, 1);
    check("t2_first_pc", o_id_pc, 32'h100);
    for (int k = 1; k <= 10; k++) begin
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
      check("t2_stream_valid", o_id_valid, 1);
      check("t2_stream_pc", o_id_pc, 32'h100 + 32'(4 * k));
    end

    // Backpressure: four accepted, then one request per pop
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    fires = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
      if (o_req_fire) fires++;
    end
    check("t3_fires", fires, 4);
    check("t3_full_valid", o_id_valid, 1);
    check("t3_stalled", o_req_valid, 0);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    check("t3_pop_cycle_req", o_req_valid, 0);
    check("t3_pop_pc", o_id_pc, 32'h100);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    check("t3_resume_req", o_req_valid, 1);
    check("t3_resume_addr", o_addr, 32'h110);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    check("t3_restall", o_req_valid, 0);

    // Redirect with two fetches in flight
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    fires = 0;
    for (int k = 0; k < 2; k++) begin
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
      if (o_req_fire) fires++;
    end
    check("t4_inflight", fires, 2);
    cycle(1'b0, 1'b1, 32'h2002, 1'b1, 1'b0, 1'b1);
    check("t4_redir_req", o_req_valid, 0);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    check("t4_new_addr", o_addr, 32'h2000);
    wait_first_id(20, seen, fpc);
    check("t4_seen", seen, 1);
    check("t4_first_pc", fpc, 32'h2000);

    // Full queue, then back-to-back redirects
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    check("t5_full_stall", o_req_valid, 0);
    cycle(1'b0, 1'b1, 32'h300, 1'b1, 1'b1, 1'b1);
    check("t5_redir_id", o_id_valid, 0);
    cycle(1'b0, 1'b1, 32'h400, 1'b1, 1'b1, 1'b1);
    check("t5_redir2_req", o_req_valid, 0);
    wait_first_id(20, seen, fpc);
    check("t5_seen", seen, 1);
    check("t5_first_pc", fpc, 32'h400);

    // Redirect coinciding with a response, two more still in flight
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h500, 1'b1, 1'b1, 1'b0);
    check("t5b_redir_id", o_id_valid, 0);
    wait_first_id(20, seen, fpc);
    check("t5b_seen", seen, 1);
    check("t5b_first_pc", fpc, 32'h500);

    // Reset mid-stream, then PC wrap
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    check("t6_nonempty", o_id_valid, 1);
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    check("t6_id_after_rst", o_id_valid, 0);
    check("t6_req_after_rst", o_req_valid, 1);
    check("t6_addr_after_rst", o_addr, RST_PC);
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    check("t6_addr_top", o_addr, 32'hFFFF_FFFC);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    check("t6_addr_wrap", o_addr, 32'h0);
    wait_first_id(20, seen, fpc);
    check("t6_seen", seen, 1);
    check("t6_first_pc", fpc, 32'hFFFF_FFFC);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    check("t6_wrap_valid", o_id_valid, 1);
    check("t6_wrap_pc", o_id_pc, 32'h0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(199) == 0);
      rd = ($urandom_range(24) == 0);
      rp = $urandom;
      if ($urandom_range(3) == 0) rp = 32'hFFFF_FFF0 | 32'($urandom_range(15));
      cycle(r, rd, rp, $urandom_range(9) < 7, $urandom_range(9) < 6, $urandom_range(9) < 7);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
